// File: rtl/reg_cmd_ctrl_if.sv
// Command-controller bus: UART RX byte in, register file strobes/return, TX FIFO push.
// master = controller side, slave = environment (UART RX, register file, TX FIFO).
interface reg_cmd_ctrl_if #(
   parameter int WIDTH = 8,
   parameter int ADDR  = 4
);
   logic [WIDTH-1:0] RX_DATA;
   logic             RX_VLD;
   logic             WrEn;
   logic             RdEn;
   logic [ADDR-1:0]  Address;
   logic [WIDTH-1:0] WrData;
   logic [WIDTH-1:0] RdData;
   logic             RdData_Valid;
   logic [WIDTH-1:0] TX_DATA;
   logic             TX_VLD;
   logic             FIFO_FULL;

   modport master (
      input  RX_DATA, RX_VLD, RdData, RdData_Valid, FIFO_FULL,
      output WrEn, RdEn, Address, WrData, TX_DATA, TX_VLD
   );

   modport slave (
      output RX_DATA, RX_VLD, RdData, RdData_Valid, FIFO_FULL,
      input  WrEn, RdEn, Address, WrData, TX_DATA, TX_VLD
   );
endinterface

// File: rtl/reg_cmd_ctrl.sv
// Decodes UART bytes (AA addr data = write, BB addr = read) into 1-cycle WrEn/RdEn strobes; read data pushed to TX FIFO,
// push stalls while FIFO_FULL. Define REG_CMD_ERR_RESP_EN to answer unknown commands and read timeouts with 0xEE.
module reg_cmd_ctrl #(
   parameter int WIDTH      = 8,
   parameter int ADDR       = 4,
   parameter int RD_TIMEOUT = 15
) (
   input  logic          CLK,
   input  logic          RST,
   reg_cmd_ctrl_if.master bus
);
   localparam int CW = $clog2(RD_TIMEOUT + 1);
   localparam logic [WIDTH-1:0] CMD_WR   = WIDTH'(8'hAA);
   localparam logic [WIDTH-1:0] CMD_RD   = WIDTH'(8'hBB);
   localparam logic [WIDTH-1:0] ERR_BYTE = WIDTH'(8'hEE);

   typedef enum logic [2:0] {
      IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_PUSH
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [ADDR-1:0]  addr_q, addr_d;
   logic [WIDTH-1:0] wdata_q, wdata_d;
   logic [WIDTH-1:0] tx_q, tx_d;
   logic             wren_q, wren_d;
   logic             rden_q, rden_d;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         tx_q    <= '0;
         wren_q  <= 1'b0;
         rden_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         tx_q    <= tx_d;
         wren_q  <= wren_d;
         rden_q  <= rden_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      tx_d    = tx_q;
      wren_d  = 1'b0;
      rden_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.RX_VLD) begin
               if (bus.RX_DATA == CMD_WR) begin
                  state_d = WR_ADDR;
               end else if (bus.RX_DATA == CMD_RD) begin
                  state_d = RD_ADDR;
               end else begin
`ifdef REG_CMD_ERR_RESP_EN
                  tx_d    = ERR_BYTE;
                  state_d = TX_PUSH;
`else
                  state_d = IDLE;
`endif
               end
            end
         end
         WR_ADDR: begin
            if (bus.RX_VLD) begin
               addr_d  = bus.RX_DATA[ADDR-1:0];
               state_d = WR_DATA;
            end
         end
         WR_DATA: begin
            if (bus.RX_VLD) begin
               wdata_d = bus.RX_DATA;
               wren_d  = 1'b1;
               state_d = IDLE;
            end
         end
         RD_ADDR: begin
            if (bus.RX_VLD) begin
               addr_d  = bus.RX_DATA[ADDR-1:0];
               rden_d  = 1'b1;
               cnt_d   = '0;
               state_d = RD_WAIT;
            end
         end
         RD_WAIT: begin
            // Incoming RX bytes are dropped here; a late return still wins on the timeout cycle.
            if (bus.RdData_Valid) begin
               tx_d    = bus.RdData;
               state_d = TX_PUSH;
            end else begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_d == CW'(RD_TIMEOUT)) begin
`ifdef REG_CMD_ERR_RESP_EN
                  tx_d    = ERR_BYTE;
                  state_d = TX_PUSH;
`else
                  state_d = IDLE;
`endif
               end
            end
         end
         TX_PUSH: begin
            if (!bus.FIFO_FULL) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.WrEn    = wren_q;
   assign bus.RdEn    = rden_q;
   assign bus.Address = addr_q;
   assign bus.WrData  = wdata_q;
   assign bus.TX_DATA = tx_q;
   assign bus.TX_VLD  = (state_q == TX_PUSH) && !bus.FIFO_FULL;
endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// Bench for reg_cmd_ctrl: command-stream reference model checked every cycle, plus directed literal pins.
module tb_reg_cmd_ctrl;
   localparam int WIDTH = 8;
   localparam int ADDR = 4;
   localparam int RD_TIMEOUT = 15;

   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;

   reg_cmd_ctrl_if #(.WIDTH(WIDTH), .ADDR(ADDR)) bus ();
   reg_cmd_ctrl #(.WIDTH(WIDTH), .ADDR(ADDR), .RD_TIMEOUT(RD_TIMEOUT)) dut (
      .CLK(CLK), .RST(RST), .bus(bus)
   );

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;

   // reference model: partially received command, expected strobe cycles, pending push
   logic [7:0] pend[$];
   int         wr_cyc = -1, rd_cyc = -1;
   bit         rd_wait = 0, push_pend = 0;
   logic [7:0] m_tx = 0, m_wdata = 0;
   logic [3:0] m_addr = 0;
   logic [7:0] exp_mem[16];

   // register file responder and observation logs
   logic [7:0] mem[16];
   int         resp_at = -1, rd_delay = 1;
   logic [7:0] resp_dat = 0;
   bit         rand_full = 0;
   int         wr_n, rd_n, last_wr_cyc, last_rd_cyc, last_send;
   logic [3:0] last_wr_addr;
   logic [7:0] last_wr_dat;
   logic [7:0] push_dat[$];
   int         push_at[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
      end
   endtask

   task automatic compare();
      chk("WrEn", 32'(bus.WrEn), 32'(cyc == wr_cyc));
      chk("RdEn", 32'(bus.RdEn), 32'(cyc == rd_cyc));
      chk("Address", 32'(bus.Address), 32'(m_addr));
      chk("WrData", 32'(bus.WrData), 32'(m_wdata));
      chk("TX_DATA", 32'(bus.TX_DATA), 32'(m_tx));
      chk("TX_VLD", 32'(bus.TX_VLD), 32'(push_pend && !bus.FIFO_FULL));
   endtask

   task automatic observe();
      if (bus.WrEn === 1'b1) begin
         wr_n++; last_wr_cyc = cyc; last_wr_addr = bus.Address; last_wr_dat = bus.WrData;
         mem[bus.Address] = bus.WrData;
      end
      if (bus.RdEn === 1'b1) begin
         rd_n++; last_rd_cyc = cyc;
         resp_at = (rd_delay > 0) ? cyc + rd_delay : -1;
         resp_dat = mem[bus.Address];
      end
      if (bus.TX_VLD === 1'b1) begin
         push_dat.push_back(bus.TX_DATA);
         push_at.push_back(cyc);
      end
   endtask

   task automatic model_step();
      if (RST) begin
         pend.delete();
         wr_cyc = -1; rd_cyc = -1; rd_wait = 0; push_pend = 0;
         m_tx = 0; m_addr = 0; m_wdata = 0;
         resp_at = -1;
      end else if (push_pend) begin
         if (!bus.FIFO_FULL) push_pend = 0;
      end else if (rd_wait) begin
         if (bus.RdData_Valid) begin
            rd_wait = 0; push_pend = 1; m_tx = exp_mem[m_addr];
         end else if (cyc - rd_cyc + 1 == RD_TIMEOUT) begin
            rd_wait = 0;
`ifdef REG_CMD_ERR_RESP_EN
            push_pend = 1; m_tx = 8'hEE;
`endif
         end
      end else if (bus.RX_VLD) begin
         pend.push_back(bus.RX_DATA);
         if (pend[0] == 8'hAA) begin
            if (pend.size() == 2) m_addr = pend[1][3:0];
            else if (pend.size() == 3) begin
               m_wdata = pend[2]; wr_cyc = cyc + 1; exp_mem[m_addr] = pend[2];
               pend.delete();
            end
         end else if (pend[0] == 8'hBB) begin
            if (pend.size() == 2) begin
               m_addr = pend[1][3:0]; rd_cyc = cyc + 1; rd_wait = 1;
               pend.delete();
            end
         end else begin
            pend.delete();
`ifdef REG_CMD_ERR_RESP_EN
            push_pend = 1; m_tx = 8'hEE;
`endif
         end
      end
   endtask

   // one cycle: drive responder inputs, check outputs, advance model, move to next negedge
   task automatic tick();
      bus.RdData_Valid = (resp_at == cyc);
      bus.RdData = bus.RdData_Valid ? resp_dat : 8'($urandom);
      if (rand_full) bus.FIFO_FULL = ($urandom_range(0, 2) == 0);
      #1;
      compare();
      observe();
      model_step();
      @(negedge CLK);
      cyc++;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic send(input logic [7:0] b);
      bus.RX_VLD = 1'b1; bus.RX_DATA = b; last_send = cyc;
      tick();
      bus.RX_VLD = 1'b0; bus.RX_DATA = 8'($urandom);
   endtask

   task automatic clear_logs();
      wr_n = 0; rd_n = 0; last_wr_cyc = -1; last_rd_cyc = -1;
      push_dat.delete(); push_at.delete();
   endtask

   initial begin
      int c_a, c_u;
      for (int i = 0; i < 16; i++) begin
         mem[i] = 8'(i * 17 + 1);
         exp_mem[i] = 8'(i * 17 + 1);
      end
      clear_logs();
      RST = 1'b1;
      bus.RX_VLD = 1'b0; bus.RX_DATA = 8'h00; bus.FIFO_FULL = 1'b0;
      bus.RdData = 8'h00; bus.RdData_Valid = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      chk("rst_WrEn", 32'(bus.WrEn), 32'd0);
      chk("rst_TX_VLD", 32'(bus.TX_VLD), 32'd0);
      chk("rst_Address", 32'(bus.Address), 32'd0);
      tick();
      RST = 1'b0;
      idle(2);

      // write AA 03 5C
      clear_logs();
      send(8'hAA); send(8'h03); send(8'h5C);
      c_a = last_send;
      idle(2);
      chk("wr_count", 32'(wr_n), 32'd1);
      chk("wr_cycle", 32'(last_wr_cyc), 32'(c_a + 1));
      chk("wr_addr", 32'(last_wr_addr), 32'd3);
      chk("wr_data", 32'(last_wr_dat), 32'h5C);
      chk("wr_no_rden", 32'(rd_n), 32'd0);

      // read BB 03 with a 1-cycle register file
      clear_logs();
      rd_delay = 1;
      send(8'hBB); send(8'h03);
      c_a = last_send;
      idle(5);
      chk("rd_rden_cycle", 32'(last_rd_cyc), 32'(c_a + 1));
      chk("rd_push_count", 32'(push_dat.size()), 32'd1);
      if (push_dat.size() == 1) begin
         chk("rd_push_data", 32'(push_dat[0]), 32'h5C);
         chk("rd_push_cycle", 32'(push_at[0]), 32'(c_a + 3));
      end

      // backpressure over TX_PUSH
      clear_logs();
      bus.FIFO_FULL = 1'b1;
      send(8'hBB); send(8'h03);
      idle(12);
      chk("bp_no_push", 32'(push_dat.size()), 32'd0);
      bus.FIFO_FULL = 1'b0;
      idle(3);
      chk("bp_push_count", 32'(push_dat.size()), 32'd1);
      if (push_dat.size() == 1) chk("bp_push_data", 32'(push_dat[0]), 32'h5C);

      // unknown command, then read that never returns
      clear_logs();
      rd_delay = 0;
      send(8'h12);
      c_u = last_send;
      idle(2);
      send(8'hBB); send(8'h05);
      idle(20);
`ifdef REG_CMD_ERR_RESP_EN
      chk("err_push_count", 32'(push_dat.size()), 32'd2);
      if (push_dat.size() == 2) begin
         chk("err_unknown_data", 32'(push_dat[0]), 32'hEE);
         chk("err_unknown_cycle", 32'(push_at[0]), 32'(c_u + 1));
         chk("err_timeout_data", 32'(push_dat[1]), 32'hEE);
         chk("err_timeout_cycle", 32'(push_at[1]), 32'(last_rd_cyc + RD_TIMEOUT));
      end
`else
      chk("err_push_count", 32'(push_dat.size()), 32'd0);
      chk("err_rden_seen", 32'(rd_n), 32'd1);
`endif
      send(8'hAA); send(8'h01); send(8'h77);
      idle(2);
      chk("after_to_wr_count", 32'(wr_n), 32'd1);
      chk("after_to_wr_data", 32'(last_wr_dat), 32'h77);

      // reset mid-command
      clear_logs();
      rd_delay = 1;
      send(8'hAA); send(8'h07);
      RST = 1'b1; tick(); RST = 1'b0;
      chk("midrst_Address", 32'(bus.Address), 32'd0);
      send(8'h5C);
      idle(3);
      chk("midrst_no_wren", 32'(wr_n), 32'd0);
`ifdef REG_CMD_ERR_RESP_EN
      chk("midrst_push_count", 32'(push_dat.size()), 32'd1);
`else
      chk("midrst_push_count", 32'(push_dat.size()), 32'd0);
`endif

      // address truncation
      clear_logs();
      send(8'hAA); send(8'h13); send(8'h01);
      idle(2);
      chk("trunc_addr", 32'(last_wr_addr), 32'd3);
      chk("trunc_data", 32'(last_wr_dat), 32'h01);

      // randomized command traffic
      rand_full = 1;
      for (int i = 0; i < 300; i++) begin
         int k;
         k = $urandom_range(0, 9);
         rd_delay = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 8);
         if (k < 4) begin
            send(8'hAA); idle($urandom_range(0, 3));
            send(8'($urandom)); idle($urandom_range(0, 3));
            send(8'($urandom));
         end else if (k < 8) begin
            send(8'hBB); idle($urandom_range(0, 3));
            send(8'($urandom));
         end else if (k == 8) begin
            send(8'($urandom));
         end else begin
            RST = 1'b1; tick(); RST = 1'b0;
         end
         idle($urandom_range(0, 20));
      end
      rand_full = 0;
      bus.FIFO_FULL = 1'b0;
      idle(20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
